// File: rtl/memoria_dados_param_if.sv
// Request/response bus of the LED-sequence data memory.
// Build option: define MEM_PARIDADE_EN to add the injetar_paridade request signal.
interface memoria_dados_param_if #(
  parameter int unsigned BITS_PALAVRA  = 64,
  parameter int unsigned BITS_FATIA    = 2,
  parameter int unsigned BITS_ENDERECO = 10
);
  localparam int unsigned NUM_FATIAS = BITS_PALAVRA / BITS_FATIA;

  logic                     req_valido;
  logic                     req_pronto;
  logic                     escrita;
  logic [BITS_ENDERECO-1:0] endereco;
  logic [NUM_FATIAS-1:0]    mascara;
  logic [BITS_PALAVRA-1:0]  entrada;
  logic [BITS_PALAVRA-1:0]  saida;
  logic                     saida_valida;
  logic                     erro_endereco;
  logic                     erro_paridade;
`ifdef MEM_PARIDADE_EN
  logic                     injetar_paridade;
`endif

  // Requester side (controller / testbench)
  modport master (
`ifdef MEM_PARIDADE_EN
    output injetar_paridade,
`endif
    output req_valido, escrita, endereco, mascara, entrada,
    input  req_pronto, saida, saida_valida, erro_endereco, erro_paridade
  );

  // Memory side
  modport slave (
`ifdef MEM_PARIDADE_EN
    input  injetar_paridade,
`endif
    input  req_valido, escrita, endereco, mascara, entrada,
    output req_pronto, saida, saida_valida, erro_endereco, erro_paridade
  );
endinterface

// File: rtl/memoria_dados_param.sv
// Single-port LED-sequence data memory: per-LED write mask, valid/ready requests,
// registered write-first result, address range check and a sequential clear engine
// that zeroes the array after reset or on i_limpar (keeps the array RAM-inferable).
// Build option: define MEM_PARIDADE_EN to store and check one even-parity bit per word.
module memoria_dados_param #(
  parameter int unsigned BITS_PALAVRA  = 64,
  parameter int unsigned BITS_FATIA    = 2,
  parameter int unsigned BITS_ENDERECO = 10,
  parameter int unsigned NUM_PALAVRAS  = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_limpar,
  output logic o_ocupado,
  memoria_dados_param_if.slave bus
);
  localparam int unsigned NUM_FATIAS = BITS_PALAVRA / BITS_FATIA;
  localparam int unsigned BITS_EXT   = BITS_ENDERECO + 1;

  localparam logic [BITS_ENDERECO-1:0] ULTIMO = BITS_ENDERECO'(NUM_PALAVRAS - 1);
  localparam logic [BITS_EXT-1:0]      LIMITE = BITS_EXT'(NUM_PALAVRAS);

  typedef enum logic {
    LIMPANDO = 1'b0,
    OCIOSO   = 1'b1
  } estado_t;

  estado_t                  r_estado;
  logic [BITS_ENDERECO-1:0] r_cnt;
  logic [BITS_PALAVRA-1:0]  r_mem [NUM_PALAVRAS];

  logic                     w_aceita;
  logic                     w_em_faixa;
  logic                     w_escreve;
  logic [BITS_ENDERECO-1:0] w_idx;
  logic [BITS_PALAVRA-1:0]  w_mascara_exp;
  logic [BITS_PALAVRA-1:0]  w_antiga;
  logic [BITS_PALAVRA-1:0]  w_nova;
  logic [BITS_PALAVRA-1:0]  w_resultado;
  logic                     w_erro_par;

  assign bus.req_pronto = (r_estado == OCIOSO);
  assign w_aceita       = bus.req_valido & bus.req_pronto;
  assign w_em_faixa     = ({1'b0, bus.endereco} < LIMITE);
  assign w_idx          = w_em_faixa ? bus.endereco : '0;
  // mascara=0 counts as a read: no array update
  assign w_escreve      = w_aceita & bus.escrita & w_em_faixa & (|bus.mascara);
  assign w_antiga       = r_mem[w_idx];
  assign w_nova         = (w_antiga & ~w_mascara_exp) | (bus.entrada & w_mascara_exp);
  assign w_resultado    = bus.escrita ? w_nova : w_antiga;

  // Expand the per-LED mask into a bit mask
  always_comb begin
    w_mascara_exp = '0;
    for (int k = 0; k < int'(NUM_FATIAS); k++) begin
      w_mascara_exp[k*BITS_FATIA +: BITS_FATIA] = {BITS_FATIA{bus.mascara[k]}};
    end
  end

  // Clear-engine FSM: walks r_cnt over the whole array, then idles until i_limpar
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado  <= LIMPANDO;
      r_cnt     <= '0;
      o_ocupado <= 1'b1;
    end else begin
      case (r_estado)
        LIMPANDO: begin
          if (r_cnt == ULTIMO) begin
            r_estado  <= OCIOSO;
            r_cnt     <= '0;
            o_ocupado <= 1'b0;
          end else begin
            r_cnt <= r_cnt + BITS_ENDERECO'(1);
          end
        end
        OCIOSO: begin
          if (i_limpar) begin
            r_estado  <= LIMPANDO;
            r_cnt     <= '0;
            o_ocupado <= 1'b1;
          end
        end
        default: begin
          r_estado  <= LIMPANDO;
          r_cnt     <= '0;
          o_ocupado <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: clear engine has priority, requests only reach it when idle
  always_ff @(posedge i_clock) begin
    if (r_estado == LIMPANDO) begin
      r_mem[r_cnt] <= '0;
    end else if (w_escreve) begin
      r_mem[w_idx] <= w_nova;
    end
  end

`ifdef MEM_PARIDADE_EN
  logic r_par [NUM_PALAVRAS];

  // Parity write port: even parity of the merged word, optionally inverted for error injection
  always_ff @(posedge i_clock) begin
    if (r_estado == LIMPANDO) begin
      r_par[r_cnt] <= 1'b0;
    end else if (w_escreve) begin
      r_par[w_idx] <= (^w_nova) ^ bus.injetar_paridade;
    end
  end

  // Only read-type accesses report the stored word's parity check
  assign w_erro_par = ~w_escreve & ((^w_antiga) ^ r_par[w_idx]);
`else
  assign w_erro_par = 1'b0;
`endif

  // Registered result: data and error flags qualified by a one-cycle strobe
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bus.saida         <= '0;
      bus.saida_valida  <= 1'b0;
      bus.erro_endereco <= 1'b0;
      bus.erro_paridade <= 1'b0;
    end else begin
      bus.saida_valida  <= w_aceita;
      bus.erro_endereco <= 1'b0;
      bus.erro_paridade <= 1'b0;
      if (w_aceita) begin
        if (w_em_faixa) begin
          bus.saida         <= w_resultado;
          bus.erro_paridade <= w_erro_par;
        end else begin
          bus.saida         <= '0;
          bus.erro_endereco <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_memoria_dados_param.sv
// Scoreboard bench for memoria_dados_param: a 1024-word instance for the main
// behaviour and a 1000-word instance for out-of-range addressing.
module tb_memoria_dados_param;
  typedef struct packed {
    logic [63:0] w;
    logic        ee;
    logic        ep;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic limpar = 1'b0;
  logic limpar2 = 1'b0;
  logic ocupado;
  logic ocupado2;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  always #5 clk = ~clk;

  memoria_dados_param_if #(.BITS_PALAVRA(64), .BITS_FATIA(2), .BITS_ENDERECO(10)) bus ();
  memoria_dados_param_if #(.BITS_PALAVRA(64), .BITS_FATIA(2), .BITS_ENDERECO(10)) bus2 ();

  memoria_dados_param #(
    .BITS_PALAVRA(64), .BITS_FATIA(2), .BITS_ENDERECO(10), .NUM_PALAVRAS(1024)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_limpar(limpar), .o_ocupado(ocupado), .bus(bus)
  );

  memoria_dados_param #(
    .BITS_PALAVRA(64), .BITS_FATIA(2), .BITS_ENDERECO(10), .NUM_PALAVRAS(1000)
  ) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_limpar(limpar2), .o_ocupado(ocupado2), .bus(bus2)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Issue one request on the 1024-word instance and queue its expected result
  task automatic req(input logic esc, input logic [9:0] a, input logic [31:0] m,
                     input logic [63:0] d, input logic [63:0] ew, input logic ee,
                     input logic ep);
    exp_t e;
    e.w = ew; e.ee = ee; e.ep = ep;
    bus.req_valido = 1'b1; bus.escrita = esc; bus.endereco = a;
    bus.mascara = m; bus.entrada = d;
    q1.push_back(e);
    @(posedge clk); #1;
    bus.req_valido = 1'b0;
  endtask

  // Same for the 1000-word instance
  task automatic req2(input logic esc, input logic [9:0] a, input logic [31:0] m,
                      input logic [63:0] d, input logic [63:0] ew, input logic ee);
    exp_t e;
    e.w = ew; e.ee = ee; e.ep = 1'b0;
    bus2.req_valido = 1'b1; bus2.escrita = esc; bus2.endereco = a;
    bus2.mascara = m; bus2.entrada = d;
    q2.push_back(e);
    @(posedge clk); #1;
    bus2.req_valido = 1'b0;
  endtask

  // Count busy cycles (bounded), then confirm the idle handshake state
  task automatic wait_clear(input string nm, input int expn);
    int n;
    n = 0;
    @(negedge clk);
    while (ocupado && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, 64'(n), 64'(expn));
    chk({nm, "_ocupado_low"}, 64'(ocupado), 64'd0);
    chk({nm, "_pronto_high"}, 64'(bus.req_pronto), 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor for the 1024-word instance
  always @(negedge clk) begin
    if (bus.saida_valida) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid dut: saida=%h", bus.saida);
      end else begin
        e1 = q1.pop_front();
        if ({bus.saida, bus.erro_endereco, bus.erro_paridade} !== e1) begin
          n_bad++;
          $display("FAIL result dut: got saida=%h ee=%b ep=%b expected saida=%h ee=%b ep=%b",
                   bus.saida, bus.erro_endereco, bus.erro_paridade, e1.w, e1.ee, e1.ep);
        end
      end
    end
  end

  // Monitor for the 1000-word instance
  always @(negedge clk) begin
    if (bus2.saida_valida) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid dut2: saida=%h", bus2.saida);
      end else begin
        e2 = q2.pop_front();
        if ({bus2.saida, bus2.erro_endereco, bus2.erro_paridade} !== e2) begin
          n_bad++;
          $display("FAIL result dut2: got saida=%h ee=%b ep=%b expected saida=%h ee=%b ep=%b",
                   bus2.saida, bus2.erro_endereco, bus2.erro_paridade, e2.w, e2.ee, e2.ep);
        end
      end
    end
  end

  initial begin
    bus.req_valido = 1'b0; bus.escrita = 1'b0; bus.endereco = '0;
    bus.mascara = '0; bus.entrada = '0;
    bus2.req_valido = 1'b0; bus2.escrita = 1'b0; bus2.endereco = '0;
    bus2.mascara = '0; bus2.entrada = '0;
`ifdef MEM_PARIDADE_EN
    bus.injetar_paridade = 1'b0;
    bus2.injetar_paridade = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ocupado", 64'(ocupado), 64'd1);
    chk("rst_pronto", 64'(bus.req_pronto), 64'd0);
    chk("rst_valida", 64'(bus.saida_valida), 64'd0);
    chk("rst_saida", bus.saida, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("initial_clear", 1024);

    // Top word reads as cleared
    req(1'b0, 10'h3FF, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);

    // Masked writes, write-first result, read-back
    req(1'b1, 10'd5, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    req(1'b1, 10'd5, 32'h0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    req(1'b0, 10'd5, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    req(1'b1, 10'd9, 32'h0000_FFFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0);
    req(1'b1, 10'd9, 32'hF000_0000, 64'h1111_2222_3333_4444, 64'h1100_0000_A5A5_A5A5, 1'b0, 1'b0);
    req(1'b1, 10'd9, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1100_0000_A5A5_A5A5, 1'b0, 1'b0);
    req(1'b0, 10'd9, 32'h0, 64'h0, 64'h1100_0000_A5A5_A5A5, 1'b0, 1'b0);
    req(1'b0, 10'd5, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);

`ifdef MEM_PARIDADE_EN
    // Injected parity error is reported on read only
    bus.injetar_paridade = 1'b1;
    req(1'b1, 10'd3, 32'hFFFF_FFFF, 64'h7, 64'h7, 1'b0, 1'b0);
    bus.injetar_paridade = 1'b0;
    req(1'b0, 10'd3, 32'h0, 64'h0, 64'h7, 1'b0, 1'b1);
    req(1'b1, 10'd4, 32'hFFFF_FFFF, 64'h7, 64'h7, 1'b0, 1'b0);
    req(1'b0, 10'd4, 32'h0, 64'h0, 64'h7, 1'b0, 1'b0);
`endif

    // Out-of-range handling on the 1000-word instance
    chk("dut2_pronto", 64'(bus2.req_pronto), 64'd1);
    req2(1'b1, 10'd999, 32'hFFFF_FFFF, 64'h55, 64'h55, 1'b0);
    req2(1'b1, 10'd1000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    req2(1'b0, 10'd1000, 32'h0, 64'h0, 64'h0, 1'b1);
    req2(1'b0, 10'd999, 32'h0, 64'h0, 64'h55, 1'b0);
    req2(1'b0, 10'd1023, 32'h0, 64'h0, 64'h0, 1'b1);
    req2(1'b0, 10'd0, 32'h0, 64'h0, 64'h0, 1'b0);

    // Clear command coinciding with a read
    req(1'b1, 10'd7, 32'hFFFF_FFFF, 64'h1234, 64'h1234, 1'b0, 1'b0);
    limpar = 1'b1;
    req(1'b0, 10'd7, 32'h0, 64'h0, 64'h1234, 1'b0, 1'b0);
    limpar = 1'b0;
    wait_clear("cmd_clear", 1024);
    req(1'b0, 10'd7, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    req(1'b0, 10'd5, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);

    // Reset in the middle of a clear, right after a nonzero result
    req(1'b1, 10'd11, 32'hFFFF_FFFF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b0);
    limpar = 1'b1;
    @(posedge clk); #1;
    limpar = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_ocupado", 64'(ocupado), 64'd1);
    chk("midrst_pronto", 64'(bus.req_pronto), 64'd0);
    chk("midrst_saida", bus.saida, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("post_reset_clear", 1024);
    req(1'b0, 10'd11, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
